adc_clk_soc_gen: RTL and testbench

//  Clock/start-of-conversion generator for the 12-bit SAR monitoring ADC.

---
 rtl/adc_clk_pkg.sv | 19 +
 rtl/adc_clk_soc_gen.sv | 85 ++++++++
 tb/tb_adc_clk_soc_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_clk_pkg.sv
// Shared types and constants for the SAR ADC phase-clock / SOC generator.
package adc_clk_pkg;

    localparam int NUM_PHASES = 4;

    typedef logic [1:0]            slot_t;
    typedef logic [NUM_PHASES-1:0] phase_vec_t;

    // Slot whose first count is the SOC_LF load point.
    localparam slot_t SOC_LOAD_SLOT = slot_t'(3);

    function automatic phase_vec_t phase_onehot(input slot_t slot);
        phase_vec_t v;
        v       = '0;
        v[slot] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/adc_clk_soc_gen.sv
// Four-phase non-overlapping clock generator with a frame-aligned SOC pulse.
// One LF frame is four slots of DIV CLOCK cycles; SOC_LF spans one whole frame.
module adc_clk_soc_gen
    import adc_clk_pkg::*;
#(
    parameter int DIV = 8,
    parameter int GAP = 1
) (
    input  logic CLOCK,
    input  logic RESETB,
    input  logic SOC,
    output logic SOC_LF,
    output logic PHI1,
    output logic PHI2,
    output logic PHI3,
    output logic PHI4,
    inout  wire  VDDD,
    inout  wire  GNDD
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] WIN_LO   = CW'(GAP);
    localparam logic [CW-1:0] WIN_HI   = CW'(DIV - 1 - GAP);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    slot_t         slot;
    slot_t         slot_nxt;
    logic          soc_q;
    logic          pend;
    logic          soc_edge;
    logic          load;
    phase_vec_t    phi;
    phase_vec_t    phi_nxt;

    // Supply pins carry no logic; this keeps them visibly consumed.
    wire unused_supply = VDDD ^ GNDD;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_nxt  = cnt + 1'b1;
        slot_nxt = slot;
        if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            slot_nxt = slot + 1'b1;
        end
    end

    assign soc_edge = SOC & ~soc_q;
    assign load     = (slot_nxt == SOC_LOAD_SLOT) && (cnt_nxt == '0);

    // Phases are decoded from the next state so the registered PHI lines match (slot,cnt) exactly.
    assign phi_nxt = (cnt_nxt >= WIN_LO && cnt_nxt <= WIN_HI) ? phase_onehot(slot_nxt) : '0;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLOCK or posedge RESETB) begin
        if (RESETB) begin
            cnt    <= '0;
            slot   <= '0;
            soc_q  <= 1'b0;
            pend   <= 1'b0;
            phi    <= '0;
            SOC_LF <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            slot  <= slot_nxt;
            soc_q <= SOC;
            phi   <= phi_nxt;
            if (load) begin
                // An edge landing on the load cycle is served here, not carried forward.
                SOC_LF <= pend | soc_edge;
                pend   <= 1'b0;
            end else if (soc_edge) begin
                pend <= 1'b1;
            end
        end
    end

    assign PHI1 = phi[0];
    assign PHI2 = phi[1];
    assign PHI3 = phi[2];
    assign PHI4 = phi[3];

endmodule

// File: tb/tb_adc_clk_soc_gen.sv
// Self-checking bench for adc_clk_soc_gen: scoreboard of per-edge expectations plus phase timing checks.
module tb_adc_clk_soc_gen;

    localparam int DIV = 8;
    localparam int GAP = 1;

    typedef struct {
        int         t;
        logic [3:0] phi;
        logic       soc_lf;
    } vec_t;

    logic clock  = 1'b0;
    logic resetb = 1'b1;
    logic soc    = 1'b0;
    logic soc_lf, phi1, phi2, phi3, phi4;
    wire  vddd, gndd;

    assign vddd = 1'b1;
    assign gndd = 1'b0;

    vec_t sb[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;
    int   t      = 0;

    adc_clk_soc_gen #(.DIV(DIV), .GAP(GAP)) dut (
        .CLOCK  (clock),
        .RESETB (resetb),
        .SOC    (soc),
        .SOC_LF (soc_lf),
        .PHI1   (phi1),
        .PHI2   (phi2),
        .PHI3   (phi3),
        .PHI4   (phi4),
        .VDDD   (vddd),
        .GNDD   (gndd)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] phis();
        return {phi4, phi3, phi2, phi1};
    endfunction

    // Reference phase pattern straight from the frame timing: slot = t/DIV, window GAP..DIV-1-GAP.
    function automatic logic [3:0] ref_phi(input int tt);
        int c = tt % DIV;
        int s = (tt / DIV) % 4;
        logic [3:0] v = 4'b0000;
        if (c >= GAP && c <= DIV - 1 - GAP) v[s] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    task automatic drain();
        vec_t e;
        while (sb.size() > 0 && sb[0].t <= t) begin
            e = sb.pop_front();
            if (e.t != t) check("sb_missed", e.t, t);
            check("phi", {28'd0, phis()}, {28'd0, e.phi});
            check("soc_lf", {31'd0, soc_lf}, {31'd0, e.soc_lf});
        end
    endtask

    // Drive SOC for the next edge, take that edge, then compare.
    task automatic step(input logic soc_v);
        soc = soc_v;
        @(posedge clock);
        #1;
        t++;
        drain();
    endtask

    task automatic push_ref(input int from, input int to,
                            input int lo1, input int hi1, input int lo2, input int hi2);
        vec_t e;
        for (int tt = from; tt <= to; tt++) begin
            e.t      = tt;
            e.phi    = ref_phi(tt);
            e.soc_lf = (tt >= lo1 && tt <= hi1) || (tt >= lo2 && tt <= hi2);
            sb.push_back(e);
        end
    endtask

    task automatic reset_and_release();
        soc    = 1'b0;
        resetb = 1'b1;
        sb.delete();
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        resetb = 1'b0;
        t      = 0;
    endtask

    initial begin
        logic [3:0] prev;
        int         last_rise[4];
        int         n_rise;

        tbl = '{
            '{0,  4'b0000, 1'b0}, '{1,  4'b0001, 1'b0}, '{6,  4'b0001, 1'b0},
            '{7,  4'b0000, 1'b0}, '{8,  4'b0000, 1'b0}, '{9,  4'b0010, 1'b0},
            '{14, 4'b0010, 1'b0}, '{15, 4'b0000, 1'b0}, '{17, 4'b0100, 1'b0},
            '{25, 4'b1000, 1'b0}, '{30, 4'b1000, 1'b0}, '{31, 4'b0000, 1'b0},
            '{33, 4'b0001, 1'b0}
        };

        // 1: reset holds everything low even with SOC toggling, then the first frame.
        resetb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            soc = i[0];
            @(posedge clock);
            #1;
            check("rst_phi", {28'd0, phis()}, 32'd0);
            check("rst_soc_lf", {31'd0, soc_lf}, 32'd0);
        end
        soc    = 1'b0;
        resetb = 1'b0;
        t      = 0;
        for (int i = 0; i < 13; i++) sb.push_back(tbl[i]);
        drain();
        for (int i = 0; i < 40; i++) step(1'b0);
        check("sb_empty_t1", sb.size(), 0);

        // 2: long run, non-overlap, period and width of every phase.
        push_ref(41, 1040, -1, -2, -1, -2);
        prev = phis();
        for (int k = 0; k < 4; k++) last_rise[k] = -1;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0);
            check("one_hot", {31'd0, $countones(phis()) <= 1}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                if (phis()[k] && !prev[k]) begin
                    if (last_rise[k] >= 0) check("period", t - last_rise[k], 4 * DIV);
                    last_rise[k] = t;
                end
                if (!phis()[k] && prev[k] && last_rise[k] >= 0)
                    check("width", t - last_rise[k], DIV - 2 * GAP);
            end
            prev = phis();
        end
        check("sb_empty_t2", sb.size(), 0);

        // 3: single SOC at t=5, pulse t=24..55 with exactly one PHI1 rise inside.
        reset_and_release();
        push_ref(0, 100, 24, 55, -1, -2);
        drain();
        n_rise = 0;
        prev   = phis();
        for (int tt = 1; tt <= 100; tt++) begin
            step(tt == 5);
            if (phi1 && !prev[0] && soc_lf) n_rise++;
            prev = phis();
        end
        check("phi1_in_pulse", n_rise, 1);
        check("sb_empty_t3", sb.size(), 0);

        // 4: SOC held high is one request.
        reset_and_release();
        push_ref(0, 220, 24, 55, -1, -2);
        drain();
        for (int tt = 1; tt <= 220; tt++) step(tt >= 5 && tt <= 200);
        check("sb_empty_t4", sb.size(), 0);

        // 5: two edges merge; an edge during SOC_LF goes to the next frame.
        reset_and_release();
        push_ref(0, 100, 24, 55, 56, 87);
        drain();
        for (int tt = 1; tt <= 100; tt++) step(tt == 3 || tt == 10 || tt == 30);
        check("sb_empty_t5", sb.size(), 0);

        // Edge on the load cycle itself is consumed there, leaving nothing pending.
        reset_and_release();
        push_ref(0, 100, 24, 55, -1, -2);
        drain();
        for (int tt = 1; tt <= 100; tt++) step(tt == 24);
        check("sb_empty_load_edge", sb.size(), 0);

        // 6: reset mid-frame drops the pending request and restarts the frame.
        reset_and_release();
        push_ref(0, 15, -1, -2, -1, -2);
        drain();
        for (int tt = 1; tt <= 15; tt++) step(tt == 5);
        soc    = 1'b0;
        resetb = 1'b1;
        #1;
        check("midrst_phi_now", {28'd0, phis()}, 32'd0);
        check("midrst_soc_lf_now", {31'd0, soc_lf}, 32'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
            check("midrst_phi", {28'd0, phis()}, 32'd0);
        end
        resetb = 1'b0;
        t      = 0;
        push_ref(0, 100, -1, -2, -1, -2);
        drain();
        for (int tt = 1; tt <= 100; tt++) step(1'b0);
        check("sb_empty_t6", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
